multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
Parametrised successor of the single DIV/TIMA timer. It provides one shared 16-bit divider plus NCH independent 8-bit timer channels. Each channel has modulo reload, a per-channel interrupt, a one-shot mode and optional cascading. The block sits on the CPU bus next to the legacy timer at a configurable I/O base and follows the same M-cycle (ct) timing rules.

Parameters:
NCH, 2, number of timer channels (1..4)
BASE_ADDR, 16'hFF60, address of DIV mirror; channel i registers at BASE_ADDR+1+3*i (COUNT), +2+3*i (MOD), +3+3*i (CTRL)
DIV_W, 16, shared divider width (>=10; DIV register reads div[DIV_W-1:DIV_W-8])

Ports:
clk  in  1  system clock (4 MHz domain)
rst  in  1  synchronous active-high reset
ct  in  2  M-cycle phase; reload happens only when ct==2'b00
a  in  16  bus address
din  in  8  write data
dout  out  8  combinational read data
rd  in  1  read strobe (no side effects)
wr  in  1  write strobe
int_req  out  NCH  per-channel overflow interrupt request
int_ack  in  NCH  per-channel interrupt acknowledge

Behaviour:
- Reset: div=0, all COUNT/MOD/CTRL=0, int_req=0, reload_pending=0. dout is combinational.
- div increments by 1 every clk and wraps. Any write to DIV sets div=0.
- CTRL bits: [2] enable, [1:0] tap select (00 div[9], 01 div[3], 10 div[5], 11 div[7]), [3] one-shot, [4] cascade. CTRL reads {3'b111, ctrl[4:0]}.
- Tick source (per channel): tap = enable & selected div bit. A tick is a 1->0 edge of tap against its registered copy. Disabling the channel or changing the tap while tap=1 therefore produces a tick; this is required.
- Tick: COUNT<=COUNT+1, mod 256. On 0xFF->0x00 (overflow): int_req[i]<=1 and reload_pending[i]<=1 in the same cycle. If one-shot, ctrl[2]<=0 in the same cycle.
- Reload: on the first cycle with reload_pending[i]=1 and ct==00, COUNT<=MOD and reload_pending<=0. This reload cycle is the "reload window".
- Write priority per channel, in the same cycle:
  - CTRL write: takes effect. Any tick in that cycle is still evaluated using the pre-write tap.
  - MOD write: MOD<=din. In the reload window, COUNT<=din as well (fall-through).
  - COUNT write outside the reload window: wins over a tick. The tick is lost and no overflow occurs. Writing COUNT while reload_pending=1 cancels the pending reload.
  - COUNT write in the reload window: ignored. COUNT<=MOD.
- Interrupts: int_ack[i] with int_req[i]=1 clears int_req[i]. If an overflow coincides with the ack, int_req[i] stays 1.
- Reads: DIV, COUNT, MOD, CTRL as mapped. Unmapped addresses read 8'hFF, including channel slots >= NCH.
- Cascade: channel i>0 with ctrl[4]=1 and ctrl[2]=1 ticks in the cycle channel i-1 overflows, ignoring its tap select. Ticks chain combinationally within a single cycle. ctrl[4] on channel 0 is ignored.
- Reset mid-operation: every state, including pending reloads and interrupts, returns to its reset value on the next edge.

Optional Feature:
MULTI_TIMER_CASCADE_EN. Defined: cascade behaves as above. Undefined: ctrl[4] is not stored, reads 0 and never alters tick source. Reads of CTRL then return {3'b111, 1'b0, ctrl[3:0]}.

Test Plan:
- Reset, then CTRL0=0x05 (enable, div[3]): COUNT0 increments every 16 clk. The first tick occurs exactly 16 clk after the div[3] edge.
- MOD0=0xF0, COUNT0=0xFF, enabled: the next tick gives COUNT0=0x00 and int_req[0]=1. At the next ct==00 cycle COUNT0=0xF0. Pulse int_ack[0] and int_req[0] drops.
- In the reload window, write MOD0=0x33: COUNT0=0x33. A COUNT0=0x77 write in the same window is ignored.
- One-shot: CTRL1=0x0D, COUNT1=0xFF. After overflow CTRL1 reads 0xE9, COUNT1 holds MOD1 and no further ticks occur.
- Cascade (macro on): CTRL0=0x05 with COUNT0=0xFF; CTRL1=0x14 with COUNT1=0x10. On channel 0 overflow COUNT1=0x11 in the same cycle. With the macro off, COUNT1 stays 0x10 and CTRL1 reads 0xE4.
- Set CTRL0=0x04 with div[9]=1, then write DIV: div=0 and COUNT0 increments once. Reading BASE_ADDR+1+3*NCH returns 0xFF.

Source files
------------

// File: rtl/multi_timer.sv
// Shared divider plus NCH 8-bit modulo timer channels with per-channel interrupts.
// Define MULTI_TIMER_CASCADE_EN to allow channel i to count overflows of channel i-1.
module multi_timer #(
  parameter int          NCH       = 2,
  parameter logic [15:0] BASE_ADDR = 16'hFF60,
  parameter int          DIV_W     = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     ct,
  input  logic [15:0]    a,
  input  logic [7:0]     din,
  output logic [7:0]     dout,
  input  logic           rd,
  input  logic           wr,
  output logic [NCH-1:0] int_req,
  input  logic [NCH-1:0] int_ack
);

`ifdef MULTI_TIMER_CASCADE_EN
  localparam bit CASC_EN = 1'b1;
`else
  localparam bit CASC_EN = 1'b0;
`endif
  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       count_q [NCH];
  logic [7:0]       count_d [NCH];
  logic [7:0]       mod_q [NCH];
  logic [7:0]       mod_d [NCH];
  logic [4:0]       ctrl_q [NCH];
  logic [4:0]       ctrl_d [NCH];
  logic [NCH-1:0]   tap_q, tap_d;
  logic [NCH-1:0]   int_req_q, int_req_d;
  logic [NCH-1:0]   pend_q, pend_d;

  logic sel, tick, ovf, casc, in_window, hit_count, hit_mod, hit_ctrl;
  logic unused_sig;

  assign unused_sig = ^{rd, div_q};
  assign int_req    = int_req_q;

  always_comb begin
    div_d = div_q + DIV_ONE;
    if (wr && a == BASE_ADDR) div_d = '0;
    tap_d     = '0;
    pend_d    = pend_q;
    int_req_d = int_req_q & ~int_ack;
    sel = 1'b0; tick = 1'b0; ovf = 1'b0; casc = 1'b0; in_window = 1'b0;
    hit_count = 1'b0; hit_mod = 1'b0; hit_ctrl = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      count_d[i] = count_q[i];
      mod_d[i]   = mod_q[i];
      ctrl_d[i]  = ctrl_q[i];
      case (ctrl_q[i][1:0])
        2'b00:   sel = div_q[9];
        2'b01:   sel = div_q[3];
        2'b10:   sel = div_q[5];
        default: sel = div_q[7];
      endcase
      // Tap uses the pre-write CTRL, so disabling or retapping while high yields a tick.
      tap_d[i]  = ctrl_q[i][2] & sel;
      hit_count = wr && (a == BASE_ADDR + 16'(3*i+1));
      hit_mod   = wr && (a == BASE_ADDR + 16'(3*i+2));
      hit_ctrl  = wr && (a == BASE_ADDR + 16'(3*i+3));
      in_window = pend_q[i] && (ct == 2'b00);
      if (CASC_EN && i > 0 && ctrl_q[i][4] && ctrl_q[i][2]) tick = casc;
      else tick = tap_q[i] & ~tap_d[i];
      ovf = 1'b0;
      if (in_window) begin
        count_d[i] = hit_mod ? din : mod_q[i];
        pend_d[i]  = 1'b0;
      end else if (hit_count) begin
        count_d[i] = din;
        pend_d[i]  = 1'b0;
      end else if (tick) begin
        count_d[i] = count_q[i] + 8'd1;
        if (count_q[i] == 8'hFF) begin
          ovf          = 1'b1;
          pend_d[i]    = 1'b1;
          int_req_d[i] = 1'b1;
          if (ctrl_q[i][3]) ctrl_d[i][2] = 1'b0;
        end
      end
      if (hit_mod)  mod_d[i]  = din;
      if (hit_ctrl) ctrl_d[i] = {CASC_EN & din[4], din[3:0]};
      casc = ovf;
    end
  end

  always_comb begin
    dout = 8'hFF;
    if (a == BASE_ADDR) dout = div_q[DIV_W-1 -: 8];
    for (int i = 0; i < NCH; i++) begin
      if (a == BASE_ADDR + 16'(3*i+1)) dout = count_q[i];
      if (a == BASE_ADDR + 16'(3*i+2)) dout = mod_q[i];
      if (a == BASE_ADDR + 16'(3*i+3)) dout = {3'b111, ctrl_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      tap_q     <= '0;
      int_req_q <= '0;
      pend_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= '0;
        mod_q[i]   <= '0;
        ctrl_q[i]  <= '0;
      end
    end else begin
      div_q     <= div_d;
      tap_q     <= tap_d;
      int_req_q <= int_req_d;
      pend_q    <= pend_d;
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= count_d[i];
        mod_q[i]   <= mod_d[i];
        ctrl_q[i]  <= ctrl_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: stimulus queues expected values, a negedge monitor checks them.
module tb_multi_timer;
  localparam logic [15:0] B = 16'hFF60;
`ifdef MULTI_TIMER_CASCADE_EN
  localparam bit CASC = 1'b1;
`else
  localparam bit CASC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ct = 2'b01;
  logic [15:0] a = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  int_req;
  logic [1:0]  int_ack = 2'b00;
  logic        chk_irq = 1'b0;
  logic [15:0] div_m = 16'h0000;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    string      name;
    bit         is_irq;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];

  multi_timer #(.NCH(2), .BASE_ADDR(B), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .ct(ct), .a(a), .din(din), .dout(dout),
    .rd(rd), .wr(wr), .int_req(int_req), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  // Reference divider value, used only to time the stimulus.
  initial forever begin
    @(posedge clk);
    if (rst || (wr && a == B)) div_m = 16'h0000;
    else div_m = div_m + 16'h0001;
  end

  initial forever begin
    @(negedge clk);
    if (rd || chk_irq) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty got=none required=entry");
      end else begin
        exp_t e;
        logic [7:0] got;
        e = sb.pop_front();
        got = e.is_irq ? {6'b0, int_req} : dout;
        total++;
        if (got !== e.exp) begin
          bad++;
          $display("FAIL %s got=%02h required=%02h", e.name, got, e.exp);
        end else begin
          $display("chk %s got=%02h exp=%02h ok", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] d);
    a = addr; din = d; wr = 1'b1;
    step();
    wr = 1'b0; a = 16'h0000;
  endtask

  task automatic rd_chk(input logic [15:0] addr, input logic [7:0] e, input string nm);
    exp_t t;
    t.name = nm; t.is_irq = 1'b0; t.exp = e;
    sb.push_back(t);
    a = addr; rd = 1'b1;
    step();
    rd = 1'b0; a = 16'h0000;
  endtask

  task automatic irq_chk(input logic [7:0] e, input string nm);
    exp_t t;
    t.name = nm; t.is_irq = 1'b1; t.exp = e;
    sb.push_back(t);
    chk_irq = 1'b1;
    step();
    chk_irq = 1'b0;
  endtask

  task automatic ack(input logic [1:0] m);
    int_ack = m;
    step();
    int_ack = 2'b00;
  endtask

  task automatic run_until_div(input logic [15:0] v);
    int n = 0;
    while (div_m != v) begin
      step();
      n++;
      if (n > 5000) begin
        total++; bad++;
        $display("FAIL div_wait got=%04h required=%04h", div_m, v);
        break;
      end
    end
  endtask

  initial begin
    repeat (3) step();
    rd_chk(B + 16'd1, 8'h00, "rst_count0");
    rd_chk(B + 16'd3, 8'hE0, "rst_ctrl0");
    rd_chk(B + 16'd6, 8'hE0, "rst_ctrl1");
    rd_chk(B,         8'h00, "rst_div");
    irq_chk(8'h00, "rst_irq");
    rst = 1'b0;

    // Free-running tick on div[3]
    wr_reg(B + 16'd3, 8'h05);
    run_until_div(16'd16);
    rd_chk(B + 16'd1, 8'h00, "tick1_before");
    rd_chk(B + 16'd1, 8'h01, "tick1_after");
    run_until_div(16'd32);
    rd_chk(B + 16'd1, 8'h01, "tick2_before");
    rd_chk(B + 16'd1, 8'h02, "tick2_after");
    wr_reg(B + 16'd3, 8'h00);
    run_until_div(16'h0345);
    rd_chk(B, 8'h03, "div_hi");

    // Overflow, interrupt, reload at ct==00, acknowledge
    wr_reg(B, 8'h00);
    wr_reg(B + 16'd2, 8'hF0);
    wr_reg(B + 16'd1, 8'hFF);
    wr_reg(B + 16'd3, 8'h05);
    run_until_div(16'd16);
    rd_chk(B + 16'd1, 8'hFF, "ovf_before");
    rd_chk(B + 16'd1, 8'h00, "ovf_wrap");
    irq_chk(8'h01, "ovf_irq");
    ct = 2'b00;
    rd_chk(B + 16'd1, 8'h00, "reload_window");
    ct = 2'b01;
    rd_chk(B + 16'd1, 8'hF0, "reloaded");
    ack(2'b01);
    irq_chk(8'h00, "ack_clear");
    wr_reg(B + 16'd3, 8'h00);

    // Writes inside and around the reload window
    wr_reg(B, 8'h00);
    wr_reg(B + 16'd1, 8'hFF);
    wr_reg(B + 16'd3, 8'h05);
    run_until_div(16'd17);
    ct = 2'b00;
    wr_reg(B + 16'd2, 8'h33);
    ct = 2'b01;
    rd_chk(B + 16'd1, 8'h33, "mod_fallthru");
    rd_chk(B + 16'd2, 8'h33, "mod_written");
    wr_reg(B + 16'd1, 8'hFF);
    run_until_div(16'd33);
    ct = 2'b00;
    wr_reg(B + 16'd1, 8'h77);
    ct = 2'b01;
    rd_chk(B + 16'd1, 8'h33, "count_wr_in_window");
    wr_reg(B + 16'd1, 8'hFF);
    run_until_div(16'd49);
    wr_reg(B + 16'd1, 8'h42);
    ct = 2'b00;
    rd_chk(B + 16'd1, 8'h42, "pending_cancel_a");
    ct = 2'b01;
    rd_chk(B + 16'd1, 8'h42, "pending_cancel_b");
    ack(2'b01);
    irq_chk(8'h00, "ack_clear2");
    run_until_div(16'd64);
    wr_reg(B + 16'd1, 8'hFF);
    rd_chk(B + 16'd1, 8'hFF, "count_wr_beats_tick");
    irq_chk(8'h00, "no_ovf_on_lost_tick");
    run_until_div(16'd80);
    ack(2'b01);
    irq_chk(8'h01, "ovf_beats_ack");
    rd_chk(B + 16'd1, 8'h00, "ovf_with_ack");
    ack(2'b01);
    irq_chk(8'h00, "ack_clear3");
    wr_reg(B + 16'd3, 8'h00);

    // One-shot on channel 1
    wr_reg(B, 8'h00);
    wr_reg(B + 16'd5, 8'h5A);
    wr_reg(B + 16'd4, 8'hFF);
    wr_reg(B + 16'd6, 8'h0D);
    run_until_div(16'd17);
    rd_chk(B + 16'd6, 8'hE9, "oneshot_ctrl");
    rd_chk(B + 16'd4, 8'h00, "oneshot_wrap");
    ct = 2'b00;
    rd_chk(B + 16'd4, 8'h00, "oneshot_window");
    ct = 2'b01;
    run_until_div(16'd40);
    rd_chk(B + 16'd4, 8'h5A, "oneshot_stopped");
    irq_chk(8'h02, "oneshot_irq");
    ack(2'b10);
    irq_chk(8'h00, "ack_clear4");

    // Cascade channel 1 from channel 0
    wr_reg(B, 8'h00);
    wr_reg(B + 16'd1, 8'hFF);
    wr_reg(B + 16'd3, 8'h05);
    wr_reg(B + 16'd4, 8'h10);
    wr_reg(B + 16'd6, 8'h14);
    run_until_div(16'd17);
    rd_chk(B + 16'd4, CASC ? 8'h11 : 8'h10, "cascade_count1");
    rd_chk(B + 16'd6, CASC ? 8'hF4 : 8'hE4, "cascade_ctrl1");
    rd_chk(B + 16'd1, 8'h00, "cascade_count0");
    irq_chk(8'h01, "cascade_irq");
    wr_reg(B + 16'd3, 8'h00);
    wr_reg(B + 16'd6, 8'h00);
    ack(2'b01);
    irq_chk(8'h00, "ack_clear5");

    // DIV write while div[9] tap is high gives exactly one tick
    wr_reg(B + 16'd1, 8'h20);
    run_until_div(16'd600);
    wr_reg(B + 16'd3, 8'h04);
    wr_reg(B, 8'h00);
    rd_chk(B, 8'h00, "div_cleared");
    rd_chk(B + 16'd1, 8'h21, "div_wr_tick");
    rd_chk(B + 16'd7, 8'hFF, "unmapped_slot");
    rd_chk(B - 16'd1, 8'hFF, "unmapped_below");

    // Reset in the middle of operation
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_chk(B + 16'd1, 8'h00, "midrst_count0");
    rd_chk(B + 16'd3, 8'hE0, "midrst_ctrl0");
    rd_chk(B + 16'd5, 8'h00, "midrst_mod1");
    irq_chk(8'h00, "midrst_irq");

    step();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
